// File: rtl/pci_pkg.sv
// Shared PCI bus definitions: FSM state encoding, bus commands and idle/active control levels.
// Used by the target, initiator and arbiter models.
package pci_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_TURN   = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_FINISH = 3'd4;

    localparam logic [3:0] CMD_WRITE = 4'h0;
    localparam logic [3:0] CMD_READ  = 4'h1;

    localparam logic DEVSEL_IDLE   = 1'b1;
    localparam logic DEVSEL_ACTIVE = 1'b0;
    localparam logic TRDY_IDLE     = 1'b1;
    localparam logic TRDY_ACTIVE   = 1'b0;

    typedef enum logic {
        OP_WRITE = 1'b0,
        OP_READ  = 1'b1
    } op_t;

    // Merge new data into an old word on the lanes whose active-low byte enable is 0.
    function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be_n);
        logic [31:0] result;
        result = old_word;
        for (int i = 0; i < 4; i++) begin
            if (!be_n[i]) result[8*i +: 8] = new_word[8*i +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/pci_target_buffer.sv
// Word buffer for the PCI target: DEPTH x 32 storage, byte-enable write port,
// asynchronous read port, cleared by reset.
module pci_target_buffer
    import pci_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [3:0]       be_n,
    input  logic [31:0]      wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= be_merge(mem[waddr], wdata, be_n);
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pci_target_device.sv
// PCI target: decodes the address phase, claims with devsel, paces data phases with trdy.
// Optional target disconnect at the buffer end is enabled by defining PCI_TGT_DISCONNECT_EN.
module pci_target_device
    import pci_pkg::*;
#(
    parameter logic [1:0] DEV_ID      = 2'd0,
    parameter int         DEPTH       = 8,
    parameter int         WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    inout  wire  [31:0] AD,
    input  logic [3:0]  C_BE,
    input  logic        frame,
    input  logic        irdy,
    output logic        devsel,
    output logic        trdy,
`ifdef PCI_TGT_DISCONNECT_EN
    output logic        stop,
`endif
    output logic        busy
);

    localparam int         PTR_W     = $clog2(DEPTH);
    localparam bit         HAS_WAIT  = (WAIT_CYCLES > 0);
    localparam logic [2:0] WAIT_LAST = HAS_WAIT ? 3'(WAIT_CYCLES - 1) : 3'd0;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    op_t              op;
    logic [PTR_W-1:0] ptr;
    logic [2:0]       wait_cnt;
    logic             frame_prev;
    logic             disc;
    logic             disc_set;
    logic             claim;
    logic             xfer;
    logic             give_up;
    logic             own;
    logic             ad_oe;
    logic [31:0]      rd_data;

    // A claim needs a fresh falling edge of frame so we never join a transaction mid-way.
    assign claim = (state == ST_IDLE) && !frame && frame_prev
                && ((C_BE == CMD_WRITE) || (C_BE == CMD_READ))
                && (AD[1:0] == DEV_ID);

    assign xfer    = (state == ST_DATA) && !disc && !irdy;
    assign give_up = frame && irdy
                  && ((state == ST_TURN) || (state == ST_WAIT) || (state == ST_DATA));

`ifdef PCI_TGT_DISCONNECT_EN
    assign disc_set = xfer && !frame && (ptr == PTR_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disc <= 1'b0;
        end else if (state_nxt == ST_FINISH || state_nxt == ST_IDLE) begin
            disc <= 1'b0;
        end else if (disc_set) begin
            disc <= 1'b1;
        end
    end
`else
    assign disc_set = 1'b0;
    assign disc     = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (claim) state_nxt = ST_TURN;
            end
            ST_TURN: begin
                if (give_up)       state_nxt = ST_FINISH;
                else if (HAS_WAIT) state_nxt = ST_WAIT;
                else               state_nxt = ST_DATA;
            end
            ST_WAIT: begin
                if (give_up)                    state_nxt = ST_FINISH;
                else if (wait_cnt == WAIT_LAST) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (xfer) begin
                    if (frame)         state_nxt = ST_FINISH;
                    else if (disc_set) state_nxt = ST_DATA;
                    else if (HAS_WAIT) state_nxt = ST_WAIT;
                    else               state_nxt = ST_DATA;
                end else if (give_up || (disc && frame)) begin
                    state_nxt = ST_FINISH;
                end
            end
            ST_FINISH: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            op         <= OP_WRITE;
            ptr        <= '0;
            wait_cnt   <= '0;
            frame_prev <= 1'b1;
        end else begin
            state      <= state_nxt;
            frame_prev <= frame;
            if (claim) begin
                op  <= (C_BE == CMD_READ) ? OP_READ : OP_WRITE;
                ptr <= AD[2 +: PTR_W];
            end else if (xfer && !disc_set) begin
                ptr <= ptr + 1'b1;
            end
            if (state == ST_WAIT && wait_cnt != WAIT_LAST) wait_cnt <= wait_cnt + 3'd1;
            else                                           wait_cnt <= '0;
        end
    end

    pci_target_buffer #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_buffer (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (xfer && (op == OP_WRITE)),
        .waddr (ptr),
        .be_n  (C_BE),
        .wdata (AD),
        .raddr (ptr),
        .rdata (rd_data)
    );

    // Control lines are driven for the whole ownership window, including FINISH where they go high.
    assign own   = (state != ST_IDLE);
    assign ad_oe = (op == OP_READ) && (state == ST_DATA) && !disc;
    assign busy  = own;

    assign devsel = own ? ((state == ST_FINISH) ? DEVSEL_IDLE : DEVSEL_ACTIVE) : 1'bz;
    assign trdy   = own ? (((state == ST_DATA) && !disc) ? TRDY_ACTIVE : TRDY_IDLE) : 1'bz;
    assign AD     = ad_oe ? rd_data : 32'bz;

`ifdef PCI_TGT_DISCONNECT_EN
    assign stop = own ? ~(disc && (state == ST_DATA)) : 1'bz;
`endif

endmodule

// File: tb/tb_pci_target_device.sv
// Self-checking bench: two targets (DEV_ID 1 no waits, DEV_ID 2 two waits) share one bus;
// a word-array reference model feeds a read-data scoreboard drained by a separate monitor.
module tb_pci_target_device;

   localparam logic [3:0] WR = 4'h0;
   localparam logic [3:0] RD = 4'h1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  cBe = 4'h0;
   logic        frame = 1'b1;
   logic        irdy = 1'b1;
   logic [31:0] tbAd = 32'h0;
   logic        tbOe = 1'b0;
   wire  [31:0] AD;
   wire         devsel1, trdy1, busy1;
   wire         devsel2, trdy2, busy2;
`ifdef PCI_TGT_DISCONNECT_EN
   wire         stop1, stop2;
`endif

   assign AD = tbOe ? tbAd : 32'bz;

   pci_target_device #(.DEV_ID(2'd1), .DEPTH(8), .WAIT_CYCLES(0)) dut1 (
      .clk(clk), .rst_n(rst_n), .AD(AD), .C_BE(cBe), .frame(frame), .irdy(irdy),
      .devsel(devsel1), .trdy(trdy1),
`ifdef PCI_TGT_DISCONNECT_EN
      .stop(stop1),
`endif
      .busy(busy1));

   pci_target_device #(.DEV_ID(2'd2), .DEPTH(8), .WAIT_CYCLES(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .AD(AD), .C_BE(cBe), .frame(frame), .irdy(irdy),
      .devsel(devsel2), .trdy(trdy2),
`ifdef PCI_TGT_DISCONNECT_EN
      .stop(stop2),
`endif
      .busy(busy2));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [31:0] mem1 [8];
   logic [31:0] mem2 [8];
   logic [31:0] expQ [$];
   logic [31:0] wdat [16];
   logic [3:0]  wbe [16];
   int  curId = 0;
   bit  curRead = 1'b0;

   // Compare one observed value against the bench's expectation.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   function automatic logic ownBusy(input int id);
      return (id == 1) ? busy1 : (id == 2) ? busy2 : 1'b0;
   endfunction
   function automatic logic ownTrdy(input int id);
      return (id == 1) ? trdy1 : trdy2;
   endfunction
   function automatic logic ownDevsel(input int id);
      return (id == 1) ? devsel1 : devsel2;
   endfunction
`ifdef PCI_TGT_DISCONNECT_EN
   function automatic logic ownStop(input int id);
      return (id == 1) ? stop1 : stop2;
   endfunction
`endif

   function automatic logic [31:0] mergeBytes(input logic [31:0] oldW, input logic [31:0] newW, input logic [3:0] beN);
      logic [31:0] r;
      r = oldW;
      for (int b = 0; b < 4; b++) if (!beN[b]) r[8*b +: 8] = newW[8*b +: 8];
      return r;
   endfunction

   // Monitor: every read transfer the DUT completes consumes one expected word.
   always @(negedge clk) begin
      #2;
      if (curRead && !irdy && ownBusy(curId) && ownTrdy(curId) == 1'b0) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected_read", AD, 32'hxxxxxxxx);
         end else begin
            checkOutput("read_data", AD, expQ.pop_front());
         end
      end
   end

   // Run one claimed transaction of n phases; stallAt is the phase that sees a 2-cycle irdy stall.
   task automatic applyStimulus(input int id, input logic [3:0] cmd, input int start, input int n, input int stallAt);
      int w, lim, idx, i, k, lastK, stallLeft, budget;
      bit stalled, stallSince, gotFirst, isRead;
      w = (id == 2) ? 2 : 0;
      isRead = (cmd == RD);
      lim = n;
`ifdef PCI_TGT_DISCONNECT_EN
      if (start + n > 8) lim = 8 - start;
`endif
      for (int p = 0; p < lim; p++) begin
         idx = (start + p) % 8;
         if (!isRead) begin
            if (id == 1) mem1[idx] = mergeBytes(mem1[idx], wdat[p], wbe[p]);
            else         mem2[idx] = mergeBytes(mem2[idx], wdat[p], wbe[p]);
         end else begin
            expQ.push_back((id == 1) ? mem1[idx] : mem2[idx]);
         end
      end
      @(negedge clk);
      curId = id; curRead = isRead;
      frame = 1'b0; irdy = 1'b1; tbOe = 1'b1; cBe = cmd;
      tbAd = {27'd0, 3'(start), 2'(id)};
      @(negedge clk);
      checkOutput("claim_busy", {31'd0, ownBusy(id)}, 32'd1);
      checkOutput("claim_devsel", {31'd0, ownDevsel(id)}, 32'd0);
      tbOe = !isRead;
      i = 0; k = 1; lastK = 0; stallLeft = 0; budget = 0;
      stalled = 0; stallSince = 0; gotFirst = 0;
      while (i < n && budget < 80) begin
         if (i == stallAt && !stalled) begin stallLeft = 2; stalled = 1; stallSince = 1; end
         irdy = (stallLeft > 0);
         tbAd = wdat[i];
         cBe = isRead ? 4'h0 : wbe[i];
         frame = (i == n - 1 && stallLeft == 0);
         #1;
         if (!irdy && ownBusy(id) && ownTrdy(id) == 1'b0) begin
            if (!gotFirst && stallAt != 0) checkOutput("first_trdy_latency", k, 2 + w);
            if (gotFirst && !stallSince) checkOutput("trdy_gap", k - lastK, w + 1);
            gotFirst = 1; stallSince = 0; lastK = k; i++;
         end
`ifdef PCI_TGT_DISCONNECT_EN
         else if (ownBusy(id) && ownStop(id) == 1'b0) begin
            checkOutput("disconnect_count", i, lim);
            frame = 1'b1; irdy = 1'b1;
            @(negedge clk);
            break;
         end
`endif
         if (stallLeft > 0) stallLeft--;
         @(negedge clk);
         k++; budget++;
      end
      if (budget >= 80) checkOutput("transaction_timeout", budget, 0);
      frame = 1'b1; irdy = 1'b1; tbOe = 1'b0;
      checkOutput("finish_levels", {29'd0, ownBusy(id), ownDevsel(id), ownTrdy(id)}, 32'd7);
      @(negedge clk);
      checkOutput("release_busy", {31'd0, ownBusy(id)}, 32'd0);
      checkOutput("scoreboard_empty", expQ.size(), 0);
      curRead = 1'b0; curId = 0;
   endtask

   // Transaction that no target should claim: busy must stay low throughout.
   task automatic applyIgnored(input logic [1:0] id, input logic [3:0] cmd);
      @(negedge clk);
      frame = 1'b0; irdy = 1'b1; tbOe = 1'b1; cBe = cmd; tbAd = {30'h5, id};
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         frame = 1'b1; irdy = 1'b0; tbAd = 32'hCAFE0000; cBe = 4'h0;
         checkOutput("ignored_busy", {30'd0, busy2, busy1}, 32'd0);
      end
      irdy = 1'b1; tbOe = 1'b0;
      @(negedge clk);
   endtask

   task automatic readAll(input int id);
      applyStimulus(id, RD, 0, 8, -1);
   endtask

   initial begin
      for (int j = 0; j < 8; j++) begin mem1[j] = 32'h0; mem2[j] = 32'h0; end
      repeat (2) @(negedge clk);
      checkOutput("reset_busy", {30'd0, busy2, busy1}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      readAll(1);
      readAll(2);

      wdat[0] = 32'hDEADBEEF; wbe[0] = 4'h0;
      applyStimulus(1, WR, 0, 1, -1);
      applyStimulus(1, RD, 0, 1, -1);

      applyIgnored(2'd3, WR);
      applyIgnored(2'd1, 4'h7);

      for (int p = 0; p < 4; p++) begin wdat[p] = 32'h10000000 * (p + 1) + 32'h00A5; wbe[p] = 4'h0; end
      applyStimulus(2, WR, 0, 4, 2);
      applyStimulus(2, RD, 0, 4, 1);

      wdat[0] = 32'hFFFFFFFF; wbe[0] = 4'h0;
      applyStimulus(1, WR, 5, 1, -1);
      wdat[0] = 32'h11223344; wbe[0] = 4'b1010;
      applyStimulus(1, WR, 5, 1, -1);
      applyStimulus(1, RD, 5, 1, -1);
      checkOutput("byte_enable_model", mem1[5], 32'hFF22FF44);

      for (int p = 0; p < 10; p++) begin wdat[p] = 32'hB0000000 + p + 1; wbe[p] = 4'h0; end
      applyStimulus(1, WR, 0, 10, -1);
      readAll(1);

      for (int r = 0; r < 14; r++) begin
         int id, st, n, sa;
         id = $urandom_range(1, 2);
         st = $urandom_range(0, 7);
         n  = $urandom_range(1, 6);
         sa = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
         for (int p = 0; p < n; p++) begin wdat[p] = $urandom; wbe[p] = 4'($urandom); end
         applyStimulus(id, ($urandom_range(0, 1) == 0) ? WR : RD, st, n, sa);
      end
      readAll(1);
      readAll(2);

      @(negedge clk);
      frame = 1'b0; irdy = 1'b1; tbOe = 1'b1; cBe = WR; tbAd = 32'h1;
      @(negedge clk);
      irdy = 1'b0; frame = 1'b0; tbAd = 32'hA5A5A5A5;
      @(negedge clk);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1 checkOutput("async_reset_release", {30'd0, busy2, busy1}, 32'd0);
      frame = 1'b1; irdy = 1'b1; tbOe = 1'b0;
      for (int j = 0; j < 8; j++) begin mem1[j] = 32'h0; mem2[j] = 32'h0; end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      readAll(1);
      readAll(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout actual=expired required=finish");
      $fatal(1, "[TB] timeout");
   end

endmodule
